display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl_pkg.sv | 19 +
 rtl/display_scan_ctrl_if.sv | 23 ++
 rtl/display_scan_ctrl_refresh_prescaler.sv | 26 ++
 rtl/display_scan_ctrl.sv | 91 +++++++++
 tb/tb_display_scan_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/display_scan_ctrl_pkg.sv
// rtl/display_scan_ctrl_pkg.sv - shared display constants and anode decode helper
package display_scan_ctrl_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam int NIB_W      = 4;

  localparam logic [NUM_DIGITS-1:0] AN_OFF      = 8'hFF;
  localparam logic [SEL_W-1:0]      FIRST_DIGIT = 3'd7;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [NIB_W-1:0] nib_t;

  // Active-low one-hot anode pattern for the given digit.
  function automatic logic [NUM_DIGITS-1:0] an_decode(input sel_t s);
    return ~(NUM_DIGITS'(1) << s);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - scan controller to mux/display bundle
interface display_scan_ctrl_if;
  import display_scan_ctrl_pkg::*;

  logic [NUM_DIGITS-1:0] digit_en;
  logic                  lz_en;
  nib_t                  nibble_in;
  sel_t                  sel;
  logic [NUM_DIGITS-1:0] an;
  logic                  blank;
  logic                  frame_start;

  modport master (
    input  digit_en, lz_en, nibble_in,
    output sel, an, blank, frame_start
  );

  modport slave (
    output digit_en, lz_en, nibble_in,
    input  sel, an, blank, frame_start
  );

endinterface

// File: rtl/display_scan_ctrl_refresh_prescaler.sv
// rtl/display_scan_ctrl_refresh_prescaler.sv - free-running slot counter with phase strobes
module refresh_prescaler #(
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_end,
  output logic             blank_end
);

  assign slot_end  = (cnt == CNT_W'(DIV - 1));
  assign blank_end = (cnt == CNT_W'(BLANK_CYCLES - 1));

  // Count 0..DIV-1 and wrap; the wrap edge closes a slot.
  always_ff @(posedge clk) begin
    if (reset || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit seven-segment scan sequencer with blanking and zero suppression
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  display_scan_ctrl_if.master bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0]      slot_cnt;
  logic                  slot_end;
  logic                  blank_end;

  sel_t                  sel_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  blank_q;
  logic                  frame_start_q;
  logic                  zero_run;
  logic                  supp;

  logic                  cur_en;
  logic                  nib_zero;
  logic                  supp_now;
  logic                  light_now;

  // The raw count and the latched suppress flag are only observed by other
  // prescaler users and by debug; nothing downstream in this block needs them.
  logic                  unused_state;
  assign unused_state = ^{slot_cnt, supp};

  refresh_prescaler #(
    .DIV          (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .cnt       (slot_cnt),
    .slot_end  (slot_end),
    .blank_end (blank_end)
  );

  // Decision terms for the digit being scanned; only consumed on the decision edge.
  always_comb begin
    cur_en    = bus.digit_en[sel_q];
    nib_zero  = (bus.nibble_in == '0);
    supp_now  = bus.lz_en & zero_run & nib_zero & (sel_q != '0);
    light_now = cur_en & ~supp_now;
  end

  // Slot sequencing: blank at slot start, light at decision edge, blank again at slot end.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q         <= FIRST_DIGIT;
      an_q          <= AN_OFF;
      blank_q       <= 1'b1;
      // The restart state is cnt==0 on digit 7, i.e. the start of a frame.
      frame_start_q <= 1'b1;
      zero_run      <= 1'b1;
      supp          <= 1'b0;
    end else begin
      frame_start_q <= slot_end && (sel_q == '0);
      if (slot_end) begin
        sel_q   <= sel_q - sel_t'(1);
        an_q    <= AN_OFF;
        blank_q <= 1'b1;
        if (sel_q == '0) begin
          zero_run <= 1'b1;
        end
      end else if (blank_end) begin
        supp <= supp_now;
        if (cur_en) begin
          zero_run <= zero_run & nib_zero;
        end
        an_q    <= light_now ? an_decode(sel_q) : AN_OFF;
        blank_q <= ~light_now;
      end
    end
  end

  assign bus.sel         = sel_q;
  assign bus.an          = an_q;
  assign bus.blank       = blank_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

  localparam int DIV = 8;
  localparam int BL  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Digit value store feeding the 8:1 mux; index = digit number.
  logic [3:0] mem [8];
  always_comb bus.nibble_in = mem[bus.sel];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: elapsed cycles since reset determine digit and phase; the
  // lit/unlit choice of each slot is decided from the frame's digits so far.
  bit         mv = 1'b0;
  int         t  = 0;
  bit         slot_lit = 1'b0;
  bit         frame_zero = 1'b1;

  function automatic int m_c();
    return t % DIV;
  endfunction

  function automatic int m_d();
    return 7 - ((t / DIV) % 8);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mv         = 1'b1;
      t          = 0;
      slot_lit   = 1'b0;
      frame_zero = 1'b1;
    end else if (mv) begin
      int c;
      int d;
      c = m_c();
      d = m_d();
      if (c == BL - 1) begin
        bit en;
        bit is_zero;
        en       = bus.digit_en[d];
        is_zero  = (mem[d] == 4'd0);
        slot_lit = en && !(bus.lz_en && frame_zero && is_zero && d != 0);
        if (en && !is_zero) frame_zero = 1'b0;
      end
      if (c == DIV - 1) begin
        slot_lit = 1'b0;
        if (d == 0) frame_zero = 1'b1;
      end
      t++;
    end
  end

  // Per-cycle comparison against the reference plus structural invariants.
  always @(negedge clk) begin
    if (mv) begin
      logic [7:0] e_an;
      int c;
      int d;
      c    = m_c();
      d    = m_d();
      e_an = slot_lit ? ~(8'h01 << d) : 8'hFF;
      check("sel", 32'(bus.sel), 32'(d));
      check("an", 32'(bus.an), 32'(e_an));
      check("blank", 32'(bus.blank), 32'(e_an == 8'hFF));
      check("frame_start", 32'(bus.frame_start), 32'(c == 0 && d == 7));
      check("cnt", 32'(dut.slot_cnt), 32'(c));
      check("an_onehot", 32'(bus.an == 8'hFF || $countones(~bus.an) == 1), 32'd1);
      check("blank_consistent", 32'(bus.blank), 32'(bus.an == 8'hFF));
      if (dut.slot_cnt < 3'(BL))
        check("blank_phase_off", 32'(bus.an), 32'hFF);
    end
  end

  task automatic set_mem(input logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0);
    mem[7] = d7; mem[6] = d6; mem[5] = d5; mem[4] = d4;
    mem[3] = d3; mem[2] = d2; mem[1] = d1; mem[0] = d0;
  endtask

  // Wait for the next frame start, then OR together every lit anode of that frame.
  task automatic frame_union(input logic [7:0] exp, input string name);
    int k;
    logic [7:0] acc;
    k = 0;
    @(negedge clk);
    while (!bus.frame_start && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
    end else begin
      acc = 8'h00;
      for (int i = 0; i < 8 * DIV; i++) begin
        acc = acc | ~bus.an;
        @(negedge clk);
      end
      check(name, 32'(acc), 32'(exp));
    end
  endtask

  task automatic wait_slot(input int d, input int c, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!(m_d() == d && m_c() == c) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    set_mem(4'd0, 4'd0, 4'd3, 4'd0, 4'd5, 4'd0, 4'd0, 4'd9);
    bus.digit_en = 8'hFF;
    bus.lz_en    = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Hand-computed pins of the first slots after reset.
    @(negedge clk);
    check("rst_sel", 32'(bus.sel), 32'd7);
    check("rst_an", 32'(bus.an), 32'hFF);
    check("rst_blank", 32'(bus.blank), 32'd1);
    check("rst_frame_start", 32'(bus.frame_start), 32'd1);
    repeat (2) @(negedge clk);
    check("d7_lit", 32'(bus.an), 32'h7F);
    repeat (6) @(negedge clk);
    check("d6_sel", 32'(bus.sel), 32'd6);
    check("d6_blank", 32'(bus.an), 32'hFF);

    frame_union(8'hFF, "union_all_en");
    bus.lz_en = 1'b1;
    frame_union(8'h3F, "union_lz");
    set_mem(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    frame_union(8'h01, "union_all_zero");
    set_mem(4'd0, 4'd0, 4'd3, 4'd0, 4'd5, 4'd0, 4'd0, 4'd9);
    bus.lz_en    = 1'b0;
    bus.digit_en = 8'h0F;
    frame_union(8'h0F, "union_en0f");
    bus.lz_en = 1'b1;
    set_mem(4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9);
    frame_union(8'h01, "union_en0f_lz");
    bus.digit_en = 8'h00;
    frame_union(8'h00, "union_none");

    // Disable digit 4 mid-active-phase: the lit anode holds until slot end.
    set_mem(4'd0, 4'd0, 4'd3, 4'd0, 4'd5, 4'd0, 4'd0, 4'd9);
    bus.lz_en    = 1'b0;
    bus.digit_en = 8'hFF;
    frame_union(8'hFF, "union_restore");
    wait_slot(4, 4, "toggle_wait");
    bus.digit_en[4] = 1'b0;
    for (int i = 5; i < DIV; i++) begin
      @(negedge clk);
      check("toggle_hold", 32'(bus.an), 32'hEF);
    end
    frame_union(8'hEF, "union_toggle");

    // One-cycle reset at cnt=5 of the digit 3 slot.
    bus.digit_en = 8'hFF;
    wait_slot(3, 5, "reset_wait");
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_sel", 32'(bus.sel), 32'd7);
    check("midrst_an", 32'(bus.an), 32'hFF);
    check("midrst_cnt", 32'(dut.slot_cnt), 32'd0);

    // Randomized traffic: inputs change at arbitrary cycles, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 9) == 0) bus.digit_en = 8'($urandom);
      if ($urandom_range(0, 19) == 0) bus.lz_en = 1'($urandom);
      if ($urandom_range(0, 3) == 0)
        mem[$urandom_range(0, 7)] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * 8 * DIV) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
